// File: rtl/div_controller.sv
// Control FSM for the sequential restoring divider.
// Sequences load, zero-divisor check and ITER shift/evaluate iterations.
// All strobes are decoded combinationally from state. In EVAL the strobes
// also depend on the subtractor sign.
module div_controller #(
  parameter int ITER  = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic             dvs_zero,
  input  logic             sign,
  input  logic             co,
  output logic             ready,
  output logic             done,
  output logic             dvz,
  output logic             ld_q,
  output logic             ld_b,
  output logic             clr_a,
  output logic             sh_aq,
  output logic             ld_a,
  output logic             sel_a,
  output logic             q_in,
  output logic             set_q,
  output logic             initcnt,
  output logic             cnten,
  output logic [CNT_W-1:0] cnt_init
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ZCHK,
    SHIFT,
    EVAL,
    DONE,
    ERR
  } state_t;

  // The counter counts up from here, so co rises on the ITER-th EVAL.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << CNT_W) - ITER);

  state_t state, state_n;

  assign cnt_init = CNT_INIT;

  // State register; reset abandons any division in flight without a done pulse
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state and strobe decode; EVAL is Mealy on the subtractor sign
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    done    = 1'b0;
    dvz     = 1'b0;
    ld_q    = 1'b0;
    ld_b    = 1'b0;
    clr_a   = 1'b0;
    sh_aq   = 1'b0;
    ld_a    = 1'b0;
    sel_a   = 1'b0;
    q_in    = 1'b0;
    set_q   = 1'b0;
    initcnt = 1'b0;
    cnten   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        ld_q    = 1'b1;
        ld_b    = 1'b1;
        clr_a   = 1'b1;
        initcnt = 1'b1;
        state_n = ZCHK;
      end
      ZCHK: begin
        // The divisor register is only valid one cycle after LOAD.
        state_n = dvs_zero ? ERR : SHIFT;
      end
      SHIFT: begin
        sh_aq   = 1'b1;
        state_n = EVAL;
      end
      EVAL: begin
        set_q = 1'b1;
        q_in  = ~sign;
        cnten = 1'b1;
        // A is kept (restored) when the trial subtraction goes negative.
        ld_a  = ~sign;
        sel_a = ~sign;
        // co reflects the count before this cycle's increment.
        state_n = co ? DONE : SHIFT;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        dvz     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
